fft_frame_scheduler: RTL and testbench

//  Frame-level sequencer for the 64-point FFT pipeline. Accepts a frame-start request and counts the 64 input samples.

---
 rtl/fft_ctrl_pkg.sv | 26 ++
 rtl/fft_mode_fifo.sv | 59 +++++
 rtl/fft_frame_scheduler.sv | 111 +++++++++++
 tb/tb_fft_frame_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared frame geometry, FSM encodings and credit-width helper for the FFT control path
package fft_ctrl_pkg;

    localparam int N_POINTS     = 64;
    localparam int IDX_W        = $clog2(N_POINTS);
    localparam int MAX_INFLIGHT = 2;

    function automatic int inflight_width(input int max_frames);
        return $clog2(max_frames + 1);
    endfunction

    localparam int CRD_W = inflight_width(MAX_INFLIGHT);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_LOAD = 1'b1
    } in_state_t;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_RUN  = 1'b1
    } out_state_t;

endpackage

// File: rtl/fft_mode_fifo.sv
// rtl/fft_mode_fifo.sv - 1-bit per-frame mode queue between the input and output stages
module fft_mode_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // An empty queue reports mode 0 rather than a stale entry.
    assign head = empty ? 1'b0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fft_frame_scheduler.sv
// rtl/fft_frame_scheduler.sv - frame sequencer: input load counting, trigger, in-flight tracking and output burst pacing
module fft_frame_scheduler
    import fft_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             data_start,
    input  logic             mode_in,
    input  logic             out_start,
    output logic             next_data,
    output logic             load_active,
    output logic [IDX_W-1:0] in_index,
    output logic             mastertrig,
    output logic             out_active,
    output logic [IDX_W-1:0] out_index,
    output logic             data_valid,
    output logic             frame_mode,
    output logic             frame_done,
    output logic [CRD_W-1:0] inflight,
    output logic             seq_err
);

    in_state_t  in_state;
    in_state_t  in_state_nxt;
    out_state_t out_state;
    out_state_t out_state_nxt;

    logic mode_latch;
    logic in_last;
    logic out_last;
    logic start_ok;
    logic start_bad;
    logic ostart_ok;
    logic ostart_bad;

    assign in_last  = (in_state == IN_LOAD) && (in_index == LAST_IDX);
    assign out_last = (out_state == OUT_RUN) && (out_index == LAST_IDX);

    // Gated by rst so no request is advertised while the block is held in reset.
    assign next_data = !rst && (in_state == IN_IDLE) && (inflight < CRD_W'(MAX_INFLIGHT));

    assign start_ok   = data_start && next_data;
    assign start_bad  = data_start && !next_data;
    assign ostart_ok  = out_start && (out_state == OUT_IDLE) && (inflight != '0);
    assign ostart_bad = out_start && !ostart_ok;

    assign load_active = (in_state == IN_LOAD);
    assign out_active  = (out_state == OUT_RUN);
    assign data_valid  = out_active;

    always_comb begin
        in_state_nxt = in_state;
        case (in_state)
            IN_IDLE: if (start_ok) in_state_nxt = IN_LOAD;
            IN_LOAD: if (in_last)  in_state_nxt = IN_IDLE;
            default: in_state_nxt = IN_IDLE;
        endcase
    end

    always_comb begin
        out_state_nxt = out_state;
        case (out_state)
            OUT_IDLE: if (ostart_ok) out_state_nxt = OUT_RUN;
            OUT_RUN:  if (out_last)  out_state_nxt = OUT_IDLE;
            default:  out_state_nxt = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_state   <= IN_IDLE;
            out_state  <= OUT_IDLE;
            in_index   <= '0;
            out_index  <= '0;
            mode_latch <= 1'b0;
            mastertrig <= 1'b0;
            frame_done <= 1'b0;
            seq_err    <= 1'b0;
            inflight   <= '0;
        end else begin
            in_state   <= in_state_nxt;
            out_state  <= out_state_nxt;
            in_index   <= (load_active && !in_last) ? in_index + 1'b1 : '0;
            out_index  <= (out_active && !out_last) ? out_index + 1'b1 : '0;
            mastertrig <= in_last;
            frame_done <= out_last;
            seq_err    <= start_bad || ostart_bad;
            if (start_ok) begin
                mode_latch <= mode_in;
            end
            // Trigger and retire on the same edge cancel out.
            case ({in_last, out_last})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    fft_mode_fifo #(
        .DEPTH(MAX_INFLIGHT)
    ) u_mode_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_last),
        .push_data(mode_latch),
        .pop      (out_last),
        .head     (frame_mode)
    );

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb/tb_fft_frame_scheduler.sv - scoreboard bench for fft_frame_scheduler with directed frame schedules
module tb_fft_frame_scheduler;
    import fft_ctrl_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             data_start;
    logic             mode_in;
    logic             out_start;
    logic             next_data;
    logic             load_active;
    logic [IDX_W-1:0] in_index;
    logic             mastertrig;
    logic             out_active;
    logic [IDX_W-1:0] out_index;
    logic             data_valid;
    logic             frame_mode;
    logic             frame_done;
    logic [CRD_W-1:0] inflight;
    logic             seq_err;

    fft_frame_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .data_start (data_start),
        .mode_in    (mode_in),
        .out_start  (out_start),
        .next_data  (next_data),
        .load_active(load_active),
        .in_index   (in_index),
        .mastertrig (mastertrig),
        .out_active (out_active),
        .out_index  (out_index),
        .data_valid (data_valid),
        .frame_mode (frame_mode),
        .frame_done (frame_done),
        .inflight   (inflight),
        .seq_err    (seq_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int idx;
        int val;
    } exp_t;

    exp_t q_ld[$];
    exp_t q_mt[$];
    exp_t q_dv[$];
    exp_t q_fd[$];
    exp_t q_se[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_cycle(input int c);
        wait_cycle(c);
        @(negedge clk);
    endtask

    task automatic issue(input int t, input bit ds, input bit m, input bit os);
        wait_cycle(t);
        data_start = ds;
        mode_in    = m;
        out_start  = os;
        wait_cycle(t + 1);
        data_start = 1'b0;
        mode_in    = 1'b0;
        out_start  = 1'b0;
    endtask

    task automatic exp_load(input int t, input int n, input int mt_inf);
        for (int i = 0; i < n; i++) q_ld.push_back('{cyc: t + 1 + i, idx: i, val: 0});
        if (n == N_POINTS) q_mt.push_back('{cyc: t + N_POINTS + 1, idx: 0, val: mt_inf});
    endtask

    task automatic exp_burst(input int u, input int m, input int n, input int fd_inf);
        for (int i = 0; i < n; i++) q_dv.push_back('{cyc: u + 1 + i, idx: i, val: m});
        if (n == N_POINTS) q_fd.push_back('{cyc: u + N_POINTS + 1, idx: 0, val: fd_inf});
    endtask

    task automatic exp_err(input int c);
        q_se.push_back('{cyc: c, idx: 0, val: 1});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (load_active) begin
            if (q_ld.size() == 0) chk("load_unexpected", int'(in_index), -1);
            else begin
                e = q_ld.pop_front();
                chk("load_cycle", cyc, e.cyc);
                chk("load_index", int'(in_index), e.idx);
            end
        end
        if (mastertrig) begin
            if (q_mt.size() == 0) chk("mastertrig_unexpected", cyc, -1);
            else begin
                e = q_mt.pop_front();
                chk("mastertrig_cycle", cyc, e.cyc);
                chk("mastertrig_inflight", int'(inflight), e.val);
            end
        end
        if (out_active || data_valid) begin
            chk("data_valid_eq_out_active", int'(data_valid), int'(out_active));
            if (q_dv.size() == 0) chk("burst_unexpected", int'(out_index), -1);
            else begin
                e = q_dv.pop_front();
                chk("burst_cycle", cyc, e.cyc);
                chk("burst_index", int'(out_index), e.idx);
                chk("burst_mode", int'(frame_mode), e.val);
            end
        end
        if (frame_done) begin
            if (q_fd.size() == 0) chk("frame_done_unexpected", cyc, -1);
            else begin
                e = q_fd.pop_front();
                chk("frame_done_cycle", cyc, e.cyc);
                chk("frame_done_inflight", int'(inflight), e.val);
            end
        end
        if (seq_err) begin
            if (q_se.size() == 0) chk("seq_err_unexpected", cyc, -1);
            else begin
                e = q_se.pop_front();
                chk("seq_err_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        data_start = 1'b0;
        mode_in    = 1'b0;
        out_start  = 1'b0;

        // reset state
        at_cycle(2);
        chk("rst_next_data", int'(next_data), 0);
        chk("rst_load_active", int'(load_active), 0);
        chk("rst_out_active", int'(out_active), 0);
        chk("rst_pulses", int'({mastertrig, frame_done, seq_err, data_valid}), 0);
        chk("rst_indices", int'({in_index, out_index}), 0);
        chk("rst_inflight", int'(inflight), 0);
        chk("rst_frame_mode", int'(frame_mode), 0);
        wait_cycle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_next_data", int'(next_data), 1);

        // single frame
        exp_load(10, N_POINTS, 1);
        issue(10, 1, 1, 0);
        at_cycle(76);
        chk("single_inflight_loaded", int'(inflight), 1);
        exp_burst(100, 1, N_POINTS, 0);
        issue(100, 0, 0, 1);
        at_cycle(166);
        chk("single_inflight_retired", int'(inflight), 0);

        // back-to-back frames
        exp_load(200, N_POINTS, 1);
        issue(200, 1, 0, 0);
        exp_load(265, N_POINTS, 2);
        issue(265, 1, 1, 0);
        at_cycle(330);
        chk("b2b_next_data_low", int'(next_data), 0);
        at_cycle(331);
        chk("b2b_inflight", int'(inflight), 2);

        // over-request and illegal output starts
        exp_err(336);
        issue(335, 1, 1, 0);
        exp_burst(340, 0, N_POINTS, 1);
        issue(340, 0, 0, 1);
        exp_err(351);
        issue(350, 0, 0, 1);
        exp_err(361);
        issue(360, 1, 0, 1);
        at_cycle(370);
        chk("over_inflight_held", int'(inflight), 2);
        chk("over_no_load", int'(load_active), 0);
        exp_burst(420, 1, N_POINTS, 0);
        issue(420, 0, 0, 1);
        exp_err(501);
        issue(500, 0, 0, 1);

        // retire and launch on the same edge
        exp_load(600, N_POINTS, 1);
        issue(600, 1, 0, 0);
        exp_load(666, N_POINTS, 1);
        exp_burst(666, 0, N_POINTS, 1);
        issue(666, 1, 1, 1);
        at_cycle(732);
        chk("simul_inflight", int'(inflight), 1);
        chk("simul_head", int'(frame_mode), 1);
        exp_burst(740, 1, N_POINTS, 0);
        issue(740, 0, 0, 1);

        // abort mid-load
        exp_load(900, 31, 0);
        issue(900, 1, 1, 0);
        wait_cycle(931);
        rst = 1'b1;
        wait_cycle(932);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_load_inflight", int'(inflight), 0);
        chk("abort_load_active", int'(load_active), 0);
        chk("abort_load_next_data", int'(next_data), 1);

        // abort mid-burst
        exp_load(940, N_POINTS, 1);
        issue(940, 1, 1, 0);
        exp_burst(1010, 1, 41, 0);
        issue(1010, 0, 0, 1);
        wait_cycle(1051);
        rst = 1'b1;
        wait_cycle(1052);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_burst_inflight", int'(inflight), 0);
        chk("abort_burst_active", int'(out_active), 0);
        chk("abort_burst_next_data", int'(next_data), 1);
        chk("abort_burst_mode", int'(frame_mode), 0);

        // queue must be empty after abort: fresh mode-0 frame
        exp_load(1060, N_POINTS, 1);
        issue(1060, 1, 0, 0);
        exp_burst(1130, 0, N_POINTS, 0);
        issue(1130, 0, 0, 1);

        at_cycle(1210);
        chk("pending_load", q_ld.size(), 0);
        chk("pending_mastertrig", q_mt.size(), 0);
        chk("pending_burst", q_dv.size(), 0);
        chk("pending_frame_done", q_fd.size(), 0);
        chk("pending_seq_err", q_se.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
